multicycle_seq_rv32i: RTL and testbench

MULTICYCLE_SEQ_RV32I -- requirements
Module: multicycle_seq_rv32i

---
 rtl/multicycle_seq_rv32i.sv | 99 +++++++++
 tb/tb_multicycle_seq_rv32i.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_seq_rv32i.sv
// Multicycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WB control FSM.
// Drives memory, IR, register-file and PC strobes; counts retired instructions.
module multicycle_seq_rv32i (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        cu_rdwrite,
  input  logic        mem_ready,
  output logic        ir_load,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        rf_write,
  output logic        pc_write,
  output logic [2:0]  state,
  output logic        trap,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_I    = 7'h13;
  localparam logic [6:0] OP_LD   = 7'h03;
  localparam logic [6:0] OP_ST   = 7'h23;
  localparam logic [6:0] OP_BR   = 7'h63;
  localparam logic [6:0] OP_LUI  = 7'h37;
  localparam logic [6:0] OP_AUI  = 7'h17;
  localparam logic [6:0] OP_JAL  = 7'h6F;
  localparam logic [6:0] OP_JALR = 7'h67;

  state_t state_q;
  logic   op_legal;
  logic   op_mem;
  logic   op_store;

  // Classify the decoded opcode as a supported RV32I major opcode.
  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LD, OP_ST, OP_BR,
      OP_LUI, OP_AUI, OP_JAL, OP_JALR: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  assign op_store = (opcode == OP_ST);
  assign op_mem   = (opcode == OP_LD) || op_store;

  // Sequencer state and retired-instruction counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      instret <= 32'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready) state_q <= S_DECODE;
        end
        S_DECODE: begin
          state_q <= op_legal ? S_EXECUTE : S_TRAP;
        end
        S_EXECUTE: begin
          state_q <= op_mem ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (mem_ready) state_q <= S_WB;
        end
        S_WB: begin
          state_q <= S_FETCH;
          instret <= instret + 32'd1;
        end
        S_TRAP: begin
          state_q <= S_TRAP;
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  assign state        = state_q;
  assign ir_load      = (state_q == S_FETCH) && mem_ready;
  assign mem_req      = (state_q == S_FETCH) || (state_q == S_MEM);
  assign mem_addr_sel = (state_q == S_MEM);
  assign mem_we       = (state_q == S_MEM) && op_store;
  assign rf_write     = (state_q == S_WB) && cu_rdwrite;
  assign pc_write     = (state_q == S_WB);
  assign trap         = (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_seq_rv32i.sv
// Self-checking bench for multicycle_seq_rv32i.
// Builds an expected per-cycle phase trace for each instruction and compares.
module tb_multicycle_seq_rv32i;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = 7'h00;
  logic        cu_rdwrite = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_load;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        rf_write;
  logic        pc_write;
  logic [2:0]  state;
  logic        trap;
  logic [31:0] instret;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_instret = 32'd0;

  multicycle_seq_rv32i dut (
    .clock(clock),
    .reset(reset),
    .opcode(opcode),
    .cu_rdwrite(cu_rdwrite),
    .mem_ready(mem_ready),
    .ir_load(ir_load),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel),
    .rf_write(rf_write),
    .pc_write(pc_write),
    .state(state),
    .trap(trap),
    .instret(instret)
  );

  always #5 clock = ~clock;

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                      7'h37, 7'h17, 7'h6F, 7'h67};
  endfunction

  function automatic logic [9:0] observed();
    return {state, ir_load, mem_req, mem_we, mem_addr_sel,
            rf_write, pc_write, trap};
  endfunction

  // Expected outputs for a phase (0 fetch,1 decode,2 exec,3 mem,4 wb,5 trap).
  function automatic logic [9:0] expect_out(input int ph, input logic [6:0] op,
                                            input logic rdw, input logic mr);
    logic [2:0] s;
    s = 3'(ph);
    return {s, (ph == 0) && mr, (ph == 0) || (ph == 3),
            (ph == 3) && (op == 7'h23), (ph == 3),
            (ph == 4) && rdw, (ph == 4), (ph == 5)};
  endfunction

  task automatic run_instr(input logic [6:0] op, input logic rdw,
                           input int fw, input int mw, output int rf_cnt);
    int seq[$];
    int ph;
    bit last;
    logic [9:0] e;
    rf_cnt = 0;
    for (int i = 0; i <= fw; i++) seq.push_back(0);
    seq.push_back(1);
    if (is_legal(op)) begin
      seq.push_back(2);
      if (op == 7'h03 || op == 7'h23)
        for (int i = 0; i <= mw; i++) seq.push_back(3);
      seq.push_back(4);
    end else begin
      seq.push_back(5);
    end
    for (int i = 0; i < seq.size(); i++) begin
      @(negedge clock);
      ph = seq[i];
      last = (i == seq.size() - 1) || (seq[i+1] != ph);
      opcode = (ph == 0) ? 7'($urandom) : op;
      cu_rdwrite = (ph == 4) ? rdw : 1'($urandom);
      mem_ready = (ph == 0 || ph == 3) ? last : 1'($urandom);
      #1;
      e = expect_out(ph, op, rdw, mem_ready);
      total_cnt++;
      if (observed() !== e)
        $display("FAIL trace op=%h cyc=%0d got=%b want=%b", op, i, observed(), e);
      else pass_cnt++;
      total_cnt++;
      if (instret !== exp_instret)
        $display("FAIL instret op=%h cyc=%0d got=%h want=%h", op, i, instret, exp_instret);
      else pass_cnt++;
      if (rf_write) rf_cnt++;
      if (ph == 4) exp_instret = exp_instret + 32'd1;
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    mem_ready = 1'($urandom);
    @(negedge clock);
    reset = 1'b0;
    mem_ready = 1'b0;
    exp_instret = 32'd0;
    #1;
    total_cnt++;
    if (state !== 3'd0 || trap !== 1'b0 || mem_req !== 1'b1 || mem_addr_sel !== 1'b0)
      $display("FAIL reset_state got st=%0d trap=%b req=%b sel=%b want 0,0,1,0",
               state, trap, mem_req, mem_addr_sel);
    else pass_cnt++;
    total_cnt++;
    if (instret !== 32'd0)
      $display("FAIL reset_instret got=%h want=0", instret);
    else pass_cnt++;
  endtask

  task automatic test_add();
    int n;
    run_instr(7'h33, 1'b1, 0, 0, n);
    total_cnt++;
    if (n !== 1) $display("FAIL add_rf_pulses got=%0d want=1", n);
    else pass_cnt++;
  endtask

  task automatic test_lw_wait();
    int n;
    run_instr(7'h03, 1'b1, 0, 3, n);
    total_cnt++;
    if (n !== 1) $display("FAIL lw_rf_pulses got=%0d want=1", n);
    else pass_cnt++;
  endtask

  task automatic test_sw();
    int n;
    run_instr(7'h23, 1'b0, 1, 1, n);
    total_cnt++;
    if (n !== 0) $display("FAIL sw_rf_pulses got=%0d want=0", n);
    else pass_cnt++;
  endtask

  task automatic test_random_legal();
    logic [6:0] ops [9];
    logic [6:0] op;
    logic rdw;
    int n;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
    for (int k = 0; k < 40; k++) begin
      op = ops[$urandom_range(0, 8)];
      rdw = 1'($urandom);
      run_instr(op, rdw, $urandom_range(0, 3), $urandom_range(0, 3), n);
      total_cnt++;
      if (n !== int'(rdw)) $display("FAIL rand_rf_pulses op=%h got=%0d want=%0d", op, n, rdw);
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset_mem();
    @(negedge clock); opcode = 7'($urandom); mem_ready = 1'b1;
    @(negedge clock); opcode = 7'h03; mem_ready = 1'b0; cu_rdwrite = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #1;
    total_cnt++;
    if (state !== 3'd3) $display("FAIL midrst_in_mem got=%0d want=3", state);
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    mem_ready = 1'b0;
    exp_instret = 32'd0;
    #1;
    total_cnt++;
    if (state !== 3'd0 || mem_addr_sel !== 1'b0 || rf_write !== 1'b0 ||
        pc_write !== 1'b0 || mem_req !== 1'b1)
      $display("FAIL midrst_after got=%b want st=0 sel=0 rf=0 pc=0 req=1", observed());
    else pass_cnt++;
    total_cnt++;
    if (instret !== 32'd0) $display("FAIL midrst_instret got=%h want=0", instret);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset_fetch();
    int n;
    run_instr(7'h13, 1'b1, 0, 0, n);
    @(negedge clock); mem_ready = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0; exp_instret = 32'd0;
    #1;
    total_cnt++;
    if (state !== 3'd0 || instret !== 32'd0 || mem_req !== 1'b1)
      $display("FAIL fetchrst got st=%0d inst=%h req=%b want 0,0,1", state, instret, mem_req);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int n;
    test_reset();
    @(negedge clock);
    mem_ready = 1'b0;
    force dut.instret = 32'hFFFFFFFF;
    #1;
    release dut.instret;
    exp_instret = 32'hFFFFFFFF;
    run_instr(7'h63, 1'b0, 0, 0, n);
    @(negedge clock);
    mem_ready = 1'b0;
    #1;
    total_cnt++;
    if (instret !== 32'h0) $display("FAIL wrap got=%h want=00000000", instret);
    else pass_cnt++;
    total_cnt++;
    if (n !== 0) $display("FAIL wrap_rf got=%0d want=0", n);
    else pass_cnt++;
  endtask

  task automatic test_trap(input logic [6:0] op);
    int n;
    logic [9:0] e;
    run_instr(op, 1'b1, $urandom_range(0, 2), 0, n);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      opcode = 7'($urandom);
      cu_rdwrite = 1'($urandom);
      mem_ready = 1'($urandom);
      #1;
      e = expect_out(5, opcode, cu_rdwrite, mem_ready);
      total_cnt++;
      if (observed() !== e || instret !== exp_instret)
        $display("FAIL trap_hold op=%h cyc=%0d got=%b/%h want=%b/%h",
                 op, i, observed(), instret, e, exp_instret);
      else pass_cnt++;
    end
    test_reset();
  endtask

  task automatic test_back_to_back();
    int n;
    run_instr(7'h03, 1'b1, 0, 0, n);
    run_instr(7'h23, 1'b0, 0, 0, n);
    run_instr(7'h6F, 1'b1, 0, 0, n);
  endtask

  initial begin
    logic [6:0] bad;
    test_reset();
    test_add();
    test_lw_wait();
    test_sw();
    test_back_to_back();
    test_random_legal();
    test_mid_reset_mem();
    test_mid_reset_fetch();
    test_wrap();
    test_trap(7'h7F);
    do bad = 7'($urandom); while (is_legal(bad));
    test_trap(bad);
    test_add();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
